// File: rtl/comparator_2bit_dataflow_pkg.sv
// Shared encodings for the 2-bit magnitude comparator slice.
// Flag codes are laid out as {x,y,z} = {gt,eq,lt}.
package comparator_2bit_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/comparator_2bit_dataflow_cmp2_core.sv
// Pure dataflow compare of A={a1,a0} against B={b1,b0}.
// Built only from AND/OR/XOR/NOT terms so no X can be manufactured internally.
module cmp2_core (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic gt,
  output logic eq,
  output logic lt
);

  logic w_msbSame;
  logic w_lsbSame;

  assign w_msbSame = ~(a1 ^ b1);
  assign w_lsbSame = ~(a0 ^ b0);

  // The LSB only decides the result when the MSBs tie.
  assign gt = (a1 & ~b1) | (w_msbSame & a0 & ~b0);
  assign eq = w_msbSame & w_lsbSame;
  assign lt = (~a1 & b1) | (w_msbSame & ~a0 & b0);

endmodule

// File: rtl/comparator_2bit_dataflow.sv
// 2-bit magnitude comparator with optional output register (REG_OUT).
// Define COMPARATOR_2BIT_DATAFLOW_STATS_EN to add saturating gt/eq/lt counters.
module comparator_2bit_dataflow
  import comparator_2bit_pkg::*;
#(
  parameter int REG_OUT = 1,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a1,
  input  logic             a0,
  input  logic             b1,
  input  logic             b0,
  output logic             x,
  output logic             y,
  output logic             z
`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
`endif
);

  logic       w_gt;
  logic       w_eq;
  logic       w_lt;
  logic [2:0] w_flags;
  logic [2:0] r_flags;

  if (CNT_W < 1) begin : g_badCntW
    $error("CNT_W must be at least 1");
  end

  cmp2_core u_core (
    .a1 (a1),
    .a0 (a0),
    .b1 (b1),
    .b0 (b0),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  assign w_flags = {w_gt, w_eq, w_lt};

  // All-zero after reset marks "no result yet"; the first live edge loads a one-hot code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= CMP_NONE;
    end else begin
      r_flags <= w_flags;
    end
  end

  assign {x, y, z} = (REG_OUT != 0) ? r_flags : w_flags;

`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
  logic [CNT_W-1:0] r_gtCnt;
  logic [CNT_W-1:0] r_eqCnt;
  logic [CNT_W-1:0] r_ltCnt;

  // Counters follow the core result, so they count even when REG_OUT=0; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gtCnt <= '0;
      r_eqCnt <= '0;
      r_ltCnt <= '0;
    end else if (stat_clr) begin
      r_gtCnt <= '0;
      r_eqCnt <= '0;
      r_ltCnt <= '0;
    end else begin
      if (w_gt && (r_gtCnt != '1)) r_gtCnt <= r_gtCnt + CNT_W'(1);
      if (w_eq && (r_eqCnt != '1)) r_eqCnt <= r_eqCnt + CNT_W'(1);
      if (w_lt && (r_ltCnt != '1)) r_ltCnt <= r_ltCnt + CNT_W'(1);
    end
  end

  assign gt_cnt = r_gtCnt;
  assign eq_cnt = r_eqCnt;
  assign lt_cnt = r_ltCnt;
`endif

endmodule

// File: tb/tb_comparator_2bit_dataflow.sv
// Self-checking bench for comparator_2bit_dataflow: integer-compare model plus directed vectors.
// Counter checks are included when COMPARATOR_2BIT_DATAFLOW_STATS_EN is defined.
module tb_comparator_2bit_dataflow;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a1 = 1'b1, a0 = 1'b1, b1 = 1'b0, b0 = 1'b0;
  logic x, y, z;
  logic x0, y0, z0;

  logic [2:0] expQ      = 3'b000;
  bit         validEdge = 1'b0;
  bit         checkEn   = 1'b0;
  int         total     = 0;
  int         bad       = 0;

`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
  logic       statClr = 1'b0;
  logic [1:0] gtCnt, eqCnt, ltCnt;
  logic [1:0] gtCnt0, eqCnt0, ltCnt0;
`endif

  always #5 clk = ~clk;

  comparator_2bit_dataflow #(.REG_OUT(1), .CNT_W(2)) dut (
    .clk (clk), .rst_n (rst_n),
    .a1 (a1), .a0 (a0), .b1 (b1), .b0 (b0),
    .x (x), .y (y), .z (z)
`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
    , .stat_clr (statClr), .gt_cnt (gtCnt), .eq_cnt (eqCnt), .lt_cnt (ltCnt)
`endif
  );

  comparator_2bit_dataflow #(.REG_OUT(0), .CNT_W(2)) dutComb (
    .clk (clk), .rst_n (rst_n),
    .a1 (a1), .a0 (a0), .b1 (b1), .b0 (b0),
    .x (x0), .y (y0), .z (z0)
`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
    , .stat_clr (statClr), .gt_cnt (gtCnt0), .eq_cnt (eqCnt0), .lt_cnt (ltCnt0)
`endif
  );

  // Reference: plain unsigned integer compare, encoded as {gt,eq,lt}.
  function automatic logic [2:0] expectFlags(input logic [1:0] a, input logic [1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (ia > ib)       return 3'b100;
    else if (ia == ib) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
    @(posedge clk);
    #2;
    {a1, a0} = a;
    {b1, b0} = b;
  endtask

  // Registered-output expectation: whatever the model says the inputs were at the last live edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ      <= 3'b000;
      validEdge <= 1'b0;
    end else begin
      expQ      <= expectFlags({a1, a0}, {b1, b0});
      validEdge <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("regFlags", {5'b0, x, y, z}, {5'b0, expQ});
      checkOutput("combFlags", {5'b0, x0, y0, z0}, {5'b0, expectFlags({a1, a0}, {b1, b0})});
      if (validEdge) checkOutput("oneHot", {7'b0, $onehot({x, y, z})}, 8'd1);
    end
  end

  logic [1:0] tabA [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
  logic [1:0] tabB [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
  logic [2:0] tabE [7] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

  initial begin
    #1 checkEn = 1'b1;

    // Reset held with A=3, B=0: no result regardless of clock.
    repeat (2) @(negedge clk);
    checkOutput("resetHold", {5'b0, x, y, z}, 8'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("firstEdge", {5'b0, x, y, z}, 8'b100);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tabA[i], tabB[i]);
      if (i > 0) begin
        @(negedge clk);
        checkOutput($sformatf("table%0d", i - 1), {5'b0, x, y, z}, {5'b0, tabE[i - 1]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("table6", {5'b0, x, y, z}, {5'b0, tabE[6]});

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        applyStimulus(2'(a), 2'(b));
      end
    end

    // Mid-cycle reset must clear the flags before the next edge.
    applyStimulus(2'b11, 2'b00);
    @(posedge clk);
    #1 checkOutput("preReset", {5'b0, x, y, z}, 8'b100);
    #2 rst_n = 1'b0;
    #1 checkOutput("midReset", {5'b0, x, y, z}, 8'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("afterReset", {5'b0, x, y, z}, 8'b100);

    // Combinational instance reacts without an edge; registered one holds.
    applyStimulus(2'b01, 2'b10);
    #1;
    checkOutput("combNoClock", {5'b0, x0, y0, z0}, 8'b001);
    checkOutput("regHoldsUntilEdge", {5'b0, x, y, z}, 8'b100);
    @(posedge clk);
    @(negedge clk);
    checkOutput("regAfterEdge", {5'b0, x, y, z}, 8'b001);

`ifdef COMPARATOR_2BIT_DATAFLOW_STATS_EN
    applyStimulus(2'b10, 2'b10);
    statClr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("clrWinsInitial", {6'b0, eqCnt}, 8'd0);
    statClr = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("eqSaturate", {6'b0, eqCnt}, 8'd3);
    checkOutput("gtIdle", {6'b0, gtCnt}, 8'd0);
    checkOutput("ltIdle", {6'b0, ltCnt}, 8'd0);
    statClr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("clrWinsSaturated", {6'b0, eqCnt}, 8'd0);
    statClr = 1'b0;
    applyStimulus(2'b00, 2'b11);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ltCount", {6'b0, ltCnt}, 8'd1);
`endif

    checkEn = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_2bit_dataflow.md
Name: comparator_2bit_dataflow

Overview:
Magnitude comparator for two 2-bit unsigned operands, A = {a1,a0} and B = {b1,b0}. It produces three mutually exclusive flags: greater-than, equal and less-than. The compare logic is pure dataflow (continuous assignments), followed by an output register stage. It sits in datapath control logic wherever a small-field compare result must be registered before use.

Parameters:
- REG_OUT, 1: 1 = flags registered (1-cycle latency); 0 = flags combinational from the inputs, and clk/rst_n affect only the optional counters.
- CNT_W, 8: width of each statistics counter; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a1  input  1  operand A MSB.
- a0  input  1  operand A LSB.
- b1  input  1  operand B MSB.
- b0  input  1  operand B LSB.
- x  output  1  A > B.
- y  output  1  A == B.
- z  output  1  A < B.

Behaviour:
- Combinational core equations:
  - gt = (a1 & ~b1) | (~(a1^b1) & a0 & ~b0)
  - eq = ~(a1^b1) & ~(a0^b0)
  - lt = (~a1 & b1) | (~(a1^b1) & ~a0 & b0)
- Operands are unsigned 0..3.
- Exactly one of gt/eq/lt is 1 for every input combination, including all 16 codes.
- REG_OUT=1:
  - x/y/z load gt/eq/lt on every rising clk edge.
  - Latency is 1 cycle; there is no enable and no handshake.
- Reset (rst_n low):
  - Asynchronous assert: x=0, y=0, z=0 immediately, independent of clk.
  - All-zero is the only legal non-one-hot state and means "no result yet".
- Reset release:
  - Deassertion is synchronized by the system.
  - The first rising edge with rst_n high loads a valid one-hot result.
- Reset mid-operation: outputs clear at once, and the pipeline value is discarded.
- REG_OUT=0:
  - x/y/z follow the inputs with zero latency.
  - rst_n does not gate the flags.
- Inputs are sampled every cycle. Input changes between edges have no effect until the next edge.
- No X propagation is permitted: the core uses only AND/OR/XOR/NOT terms.

Optional Feature:
- Macro: COMPARATOR_2BIT_DATAFLOW_STATS_EN.
- When defined, the following ports are added:
  - stat_clr input 1
  - gt_cnt output CNT_W
  - eq_cnt output CNT_W
  - lt_cnt output CNT_W
- Counter behaviour:
  - Each counter increments by 1 on each rising edge where its core result (gt/eq/lt) is 1.
  - Counters saturate at all-ones; they do not wrap.
  - Counters clear to 0 on rst_n low (asynchronous) or on stat_clr high (synchronous).
  - If stat_clr and an increment occur in the same cycle, clear wins.
- When undefined, the ports and logic are absent and the behaviour is as above.

Decomposition:
- Package comparator_2bit_pkg holds:
  - localparams CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000 ({x,y,z} encoding);
  - default CNT_W.
- Sub-module cmp2_core: purely combinational dataflow equations, inputs a1/a0/b1/b0, outputs gt/eq/lt.
- The top module holds the output register, the REG_OUT generate, and the optional counters.

Test Plan:
- Hold rst_n=0 with A=2'b11, B=2'b00 -> {x,y,z}=000 regardless of clk; release, then one edge -> 100.
- Apply the sequence below, one vector per cycle -> {x,y,z} one cycle later:

  | A  | B  | {x,y,z} |
  |----|----|---------|
  | 00 | 00 | 010     |
  | 01 | 00 | 100     |
  | 10 | 01 | 100     |
  | 11 | 10 | 100     |
  | 01 | 10 | 001     |
  | 10 | 11 | 001     |
  | 11 | 11 | 010     |

- Exhaustively apply all 16 A/B pairs -> flags match unsigned compare; the one-hot check never fails after the first post-reset edge.
- Assert rst_n low mid-cycle while the output is 100 -> the output goes to 000 before the next edge.
- REG_OUT=0: A=01, B=10 -> z=1 with no clock edge needed.
- With STATS_EN and CNT_W=2: hold A=B for 5 cycles -> eq_cnt saturates at 3; stat_clr with A==B in the same cycle -> eq_cnt=0.
